// File: rtl/icache_refill_ctrl.sv
// Instruction-cache line refill controller: one burst request per miss, beat collection, line install.
// Define ICACHE_REFILL_CWF_EN to enable critical-word-first bursts and the crit_word bypass.
module icache_refill_ctrl #(
    parameter int LINE_SIZE  = 64,
    parameter int WAYS       = 8,
    parameter int BEAT_WIDTH = 32,
    parameter int BEATS      = LINE_SIZE * 8 / BEAT_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          miss_valid,
    input  logic [31:0]                   miss_addr,
    input  logic                          flush,
    output logic                          mem_req_valid,
    input  logic                          mem_req_ready,
    output logic [31:0]                   mem_req_addr,
    input  logic                          mem_rdata_valid,
    input  logic [BEAT_WIDTH-1:0]         mem_rdata,
    output logic                          do_update_line,
    output logic                          do_update_tag_and_valid,
    output logic                          do_clear_dirty,
    output logic [31:0]                   update_addr,
    output logic [LINE_SIZE*8-1:0]        update_line_data,
    output logic [$clog2(WAYS)-1:0]       update_way,
    output logic                          update_dirty_bit,
    output logic                          busy,
    output logic                          refill_done,
    output logic                          crit_word_valid,
    output logic [BEAT_WIDTH-1:0]         crit_word
);

    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int OFF_W  = $clog2(LINE_SIZE);
    localparam int WOFF_W = $clog2(BEAT_WIDTH / 8);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RECV = 2'd2,
        FILL = 2'd3
    } state_t;

    state_t                 state, next_state;
    logic [31:0]            addr_q;
    logic [BEAT_W-1:0]      beat_cnt;
    logic [BEAT_W-1:0]      slot;
    logic [WAY_W-1:0]       victim;
    logic                   discard;
    logic [LINE_SIZE*8-1:0] line_buf;

    logic accept;
    logic beat_fire;
    logic last_beat;
    logic unused_addr_bits;

    assign accept    = (state == IDLE) && miss_valid && !flush && !rst;
    assign beat_fire = (state == RECV) && mem_rdata_valid;
    assign last_beat = beat_fire && (beat_cnt == BEAT_W'(BEATS - 1));
    assign unused_addr_bits = ^addr_q[OFF_W-1:0];

`ifdef ICACHE_REFILL_CWF_EN
    // Burst starts at the missing word, so beat j lands at (miss word + j) mod BEATS.
    assign slot         = addr_q[OFF_W-1:WOFF_W] + beat_cnt;
    assign mem_req_addr = (state == REQ) ? {addr_q[31:WOFF_W], {WOFF_W{1'b0}}} : '0;
    always_comb begin
        crit_word_valid = beat_fire && (beat_cnt == '0) && !discard && !flush;
        crit_word       = crit_word_valid ? mem_rdata : '0;
    end
`else
    assign slot            = beat_cnt;
    assign mem_req_addr    = (state == REQ) ? {addr_q[31:OFF_W], {OFF_W{1'b0}}} : '0;
    assign crit_word_valid = 1'b0;
    assign crit_word       = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state              = state;
        mem_req_valid           = 1'b0;
        do_update_line          = 1'b0;
        do_update_tag_and_valid = 1'b0;
        refill_done             = 1'b0;
        busy                    = 1'b1;
        case (state)
            IDLE: begin
                busy = accept;
                if (accept) next_state = REQ;
            end
            REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready)  next_state = RECV;
                else if (flush)     next_state = IDLE;
            end
            RECV: begin
                // A flushed burst is still drained so no stray beats reach the next miss.
                if (last_beat) next_state = (discard || flush) ? IDLE : FILL;
            end
            FILL: begin
                do_update_line          = 1'b1;
                do_update_tag_and_valid = 1'b1;
                refill_done             = 1'b1;
                next_state              = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q   <= '0;
            beat_cnt <= '0;
            victim   <= '0;
            discard  <= 1'b0;
            line_buf <= '0;
        end else begin
            if (accept) addr_q <= miss_addr;
            if (((state == REQ) && mem_req_ready || (state == RECV)) && flush)
                discard <= 1'b1;
            if (beat_fire) begin
                line_buf[slot*BEAT_WIDTH +: BEAT_WIDTH] <= mem_rdata;
                beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
            end
            if (last_beat) discard <= 1'b0;
            if (state == FILL)
                victim <= (victim == WAY_W'(WAYS - 1)) ? '0 : victim + 1'b1;
        end
    end

    assign update_addr      = {addr_q[31:OFF_W], {OFF_W{1'b0}}};
    assign update_line_data = line_buf;
    assign update_way       = victim;
    assign do_clear_dirty   = 1'b0;
    assign update_dirty_bit = 1'b0;

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Directed, table-driven bench for icache_refill_ctrl; expectations follow the build's CWF setting.
module tb_icache_refill_ctrl;

    localparam int BEATS = 16;
`ifdef ICACHE_REFILL_CWF_EN
    localparam bit CWF = 1'b1;
`else
    localparam bit CWF = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         miss_valid;
    logic [31:0]  miss_addr;
    logic         flush;
    logic         mem_req_valid;
    logic         mem_req_ready;
    logic [31:0]  mem_req_addr;
    logic         mem_rdata_valid;
    logic [31:0]  mem_rdata;
    logic         do_update_line;
    logic         do_update_tag_and_valid;
    logic         do_clear_dirty;
    logic [31:0]  update_addr;
    logic [511:0] update_line_data;
    logic [2:0]   update_way;
    logic         update_dirty_bit;
    logic         busy;
    logic         refill_done;
    logic         crit_word_valid;
    logic [31:0]  crit_word;

    icache_refill_ctrl dut (
        .clk(clk), .rst(rst),
        .miss_valid(miss_valid), .miss_addr(miss_addr), .flush(flush),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_rdata_valid(mem_rdata_valid), .mem_rdata(mem_rdata),
        .do_update_line(do_update_line), .do_update_tag_and_valid(do_update_tag_and_valid),
        .do_clear_dirty(do_clear_dirty), .update_addr(update_addr),
        .update_line_data(update_line_data), .update_way(update_way),
        .update_dirty_bit(update_dirty_bit), .busy(busy), .refill_done(refill_done),
        .crit_word_valid(crit_word_valid), .crit_word(crit_word)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          delay;
        int          flush_at;
        logic        exp_fill;
        logic [31:0] exp_uaddr;
        logic [2:0]  exp_way;
        logic [31:0] req_lin;
        logic [31:0] req_cwf;
    } vec_t;

    vec_t vecs[10];
    int   checks = 0;
    int   passes = 0;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One complete miss: request phase with optional back-pressure, 16 beats, then install or drain.
    task automatic run_miss(input vec_t v, input logic [31:0] base);
        logic [511:0] exp_line;
        logic [31:0]  exp_req;
        int           start;
        int           slot;
        int           upd_seen;
        exp_line = '0;
        upd_seen = 0;
        start    = int'(v.addr[5:2]);
        exp_req  = CWF ? v.req_cwf : v.req_lin;

        miss_valid = 1'b1; miss_addr = v.addr; flush = 1'b0;
        #1 chk("busy_on_accept", busy, 1'b1);
        chk("req_valid_idle", mem_req_valid, 1'b0);
        step();
        miss_valid = 1'b0; miss_addr = '0;
        for (int d = 0; d < v.delay; d++) begin
            mem_req_ready = 1'b0; mem_rdata_valid = 1'b1; mem_rdata = 32'hBAD0_0000 | d;
            #1 chk("req_valid_stall", mem_req_valid, 1'b1);
            chk("req_addr_stall", mem_req_addr, exp_req);
            step();
        end
        mem_rdata_valid = 1'b0; mem_req_ready = 1'b1;
        #1 chk("req_valid_hs", mem_req_valid, 1'b1);
        chk("req_addr_hs", mem_req_addr, exp_req);
        step();
        mem_req_ready = 1'b0;

        for (int j = 0; j < BEATS; j++) begin
            if (j == v.flush_at) begin
                flush = 1'b1;
                #1 chk("busy_flush", busy, 1'b1);
                step();
                flush = 1'b0;
            end
            mem_rdata_valid = 1'b1; mem_rdata = base + j;
            miss_valid = (j == 3); miss_addr = 32'hFFFF_FFC0;
            slot = CWF ? (start + j) % BEATS : j;
            exp_line[slot*32 +: 32] = base + j;
            #1 if (do_update_line) upd_seen++;
            if (j == 0) chk("single_request", mem_req_valid, 1'b0);
            chk("crit_valid", crit_word_valid, CWF && (j == 0) && (v.flush_at != 0));
            chk("crit_word", crit_word, (CWF && j == 0) ? base : 32'h0);
            step();
        end
        mem_rdata_valid = 1'b0; miss_valid = 1'b0; miss_addr = '0;
        #1 chk("no_early_update", upd_seen, 0);
        chk("do_update_line", do_update_line, v.exp_fill);
        chk("do_update_tag", do_update_tag_and_valid, v.exp_fill);
        chk("refill_done", refill_done, v.exp_fill);
        chk("busy_last", busy, v.exp_fill);
        if (v.exp_fill) begin
            chk("update_addr", update_addr, v.exp_uaddr);
            chk("update_way", update_way, v.exp_way);
            chk("update_line_data", update_line_data, exp_line);
            chk("clear_dirty", do_clear_dirty, 1'b0);
            chk("dirty_bit", update_dirty_bit, 1'b0);
        end
        step();
        #1 chk("busy_after", busy, 1'b0);
        chk("update_after", do_update_line, 1'b0);
    endtask

    initial begin
        vecs[0] = '{32'h0000_1234, 0, -1, 1'b1, 32'h0000_1200, 3'd0, 32'h0000_1200, 32'h0000_1234};
        vecs[1] = '{32'h0000_2000, 4, -1, 1'b1, 32'h0000_2000, 3'd1, 32'h0000_2000, 32'h0000_2000};
        vecs[2] = '{32'h0000_3FFC, 1,  5, 1'b0, 32'h0000_3FC0, 3'd2, 32'h0000_3FC0, 32'h0000_3FFC};
        vecs[3] = '{32'hDEAD_BEE7, 0, -1, 1'b1, 32'hDEAD_BEC0, 3'd2, 32'hDEAD_BEC0, 32'hDEAD_BEE4};
        for (int i = 4; i < 10; i++) begin
            logic [31:0] a;
            a = 32'h0001_0000 + i * 32'h104;
            vecs[i] = '{a, i % 3, -1, 1'b1, a & 32'hFFFF_FFC0, 3'((i - 1) % 8),
                        a & 32'hFFFF_FFC0, a & 32'hFFFF_FFFC};
        end

        rst = 1'b1; miss_valid = 1'b1; miss_addr = 32'h1111_1111; flush = 1'b0;
        mem_req_ready = 1'b0; mem_rdata_valid = 1'b0; mem_rdata = '0;
        repeat (2) @(negedge clk);
        #1 chk("rst_busy", busy, 1'b0);
        chk("rst_req_valid", mem_req_valid, 1'b0);
        chk("rst_req_addr", mem_req_addr, 32'h0);
        chk("rst_update_line", do_update_line, 1'b0);
        chk("rst_update_tag", do_update_tag_and_valid, 1'b0);
        chk("rst_refill_done", refill_done, 1'b0);
        chk("rst_update_addr", update_addr, 32'h0);
        chk("rst_update_way", update_way, 3'd0);
        chk("rst_line_data", update_line_data, 512'h0);
        chk("rst_crit_valid", crit_word_valid, 1'b0);
        @(negedge clk);
        miss_valid = 1'b0; rst = 1'b0;
        step();

        // flush beats a simultaneous miss in IDLE
        miss_valid = 1'b1; miss_addr = 32'h7777_0000; flush = 1'b1;
        #1 chk("flush_miss_busy", busy, 1'b0);
        step();
        miss_valid = 1'b0; flush = 1'b0;
        #1 chk("flush_miss_req", mem_req_valid, 1'b0);

        // flush while the request waits for ready
        miss_valid = 1'b1; miss_addr = 32'h8888_0000;
        step();
        miss_valid = 1'b0; flush = 1'b1;
        #1 chk("flush_req_valid", mem_req_valid, 1'b1);
        step();
        flush = 1'b0;
        #1 chk("flush_req_dropped", mem_req_valid, 1'b0);
        chk("flush_req_busy", busy, 1'b0);

        for (int i = 0; i < 10; i++) run_miss(vecs[i], 32'(i) << 16);

        // reset in the middle of receiving beats
        miss_valid = 1'b1; miss_addr = 32'h0000_5540;
        step();
        miss_valid = 1'b0; mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        for (int j = 0; j < 7; j++) begin
            mem_rdata_valid = 1'b1; mem_rdata = 32'h5500_0000 + j;
            step();
        end
        mem_rdata = 32'h5500_0007;
        #2 rst = 1'b1;
        #1 chk("midrst_busy", busy, 1'b0);
        chk("midrst_req_valid", mem_req_valid, 1'b0);
        chk("midrst_update_addr", update_addr, 32'h0);
        chk("midrst_update_way", update_way, 3'd0);
        chk("midrst_line_data", update_line_data, 512'h0);
        chk("midrst_crit_valid", crit_word_valid, 1'b0);
        step();
        rst = 1'b0;
        for (int j = 0; j < 3; j++) begin
            mem_rdata = 32'h5600_0000 + j;
            #1 chk("post_rst_busy", busy, 1'b0);
            step();
        end
        mem_rdata_valid = 1'b0;
        run_miss('{32'h0000_6680, 2, -1, 1'b1, 32'h0000_6680, 3'd0, 32'h0000_6680, 32'h0000_6680},
                 32'hA000_0000);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/icache_refill_ctrl.md
ICACHE_REFILL_CTRL -- requirements
Module: icache_refill_ctrl

Interface
REQ-001 SHALL have parameters: LINE_SIZE, 64, line bytes; WAYS, 8, associativity; BEAT_WIDTH, 32, memory beat bits; BEATS = LINE_SIZE*8/BEAT_WIDTH (derived, 16).
REQ-002 SHALL have ports: clk in 1, sole clock; rst in 1, asynchronous active-high reset.
REQ-003 miss_valid in 1 miss request (query_valid & ~query_hit); miss_addr in 32 miss byte address; flush in 1 abort.
REQ-004 mem_req_valid out 1; mem_req_ready in 1; mem_req_addr out 32 burst start address.
REQ-005 mem_rdata_valid in 1 beat strobe; mem_rdata in BEAT_WIDTH beat data.
REQ-006 do_update_line out 1; do_update_tag_and_valid out 1; do_clear_dirty out 1 (tied 0); update_addr out 32; update_line_data out LINE_SIZE*8; update_way out $clog2(WAYS); update_dirty_bit out 1 (tied 0).
REQ-007 busy out 1 stall to IF; refill_done out 1 completion pulse; crit_word_valid out 1; crit_word out BEAT_WIDTH.

Function
REQ-008 States IDLE, REQ, RECV, FILL; encoding free.
REQ-009 IDLE: miss_valid=1 & flush=0 -> capture miss_addr, go REQ next cycle; miss_valid ignored outside IDLE.
REQ-010 REQ: mem_req_valid=1, mem_req_addr stable until cycle with mem_req_ready=1, then RECV; exactly one request per miss.
REQ-011 RECV: each mem_rdata_valid writes mem_rdata into beat slot of line buffer, beat counter +1; on BEATS-th beat go FILL.
REQ-012 FILL: one cycle, do_update_line=do_update_tag_and_valid=refill_done=1, update_addr = captured addr with low $clog2(LINE_SIZE) bits zeroed, update_way = victim counter; then IDLE.
REQ-013 update_line_data: beat k at bits [k*BEAT_WIDTH +: BEAT_WIDTH]; valid only during FILL, held otherwise.
REQ-014 Victim counter: $clog2(WAYS) bits, +1 after each FILL, wraps WAYS-1 -> 0.
REQ-015 busy=1 in every state except IDLE, and in the IDLE cycle miss is accepted (combinational from miss_valid).
REQ-016 flush in IDLE/REQ (before handshake completes): return IDLE next cycle, no FILL, no counter change.
REQ-017 flush in RECV (or REQ handshake cycle): set discard flag, keep consuming beats until BEATS received, then IDLE without FILL/refill_done; busy stays 1 until drained.
REQ-018 flush and miss_valid same cycle in IDLE: flush wins, miss dropped.
REQ-019 mem_rdata_valid outside RECV ignored; beat counter wraps never beyond BEATS-1.
REQ-020 Latency: miss accepted cycle N, mem_req_ready at N+1 -> FILL at last beat cycle +1; minimum N+1+BEATS+1.

Reset
REQ-021 rst asserted (any state, any time): state IDLE, beat counter 0, victim counter 0, discard 0, all outputs 0 asynchronously; in-flight beats after release ignored.

Configuration
REQ-022 Macro ICACHE_REFILL_CWF_EN defined: critical-word-first; mem_req_addr = miss_addr with low $clog2(BEAT_WIDTH/8) bits zeroed; beat j stored in slot (start+j) mod BEATS, start = miss word index; first beat also drives crit_word, crit_word_valid=1 for that cycle (suppressed if discarding).
REQ-023 Macro undefined: mem_req_addr line-aligned; beat j to slot j; crit_word_valid and crit_word tied 0.

Verification
REQ-024 Miss 0x0000_1234, ready immediate, 16 beats data=beat idx -> one FILL, update_addr 0x0000_1200, update_way 0, slot k = k (CWF off).
REQ-025 CWF on, miss 0x0000_1234 -> mem_req_addr 0x0000_1234, crit_word_valid on beat 0 with slot 13 data, slot (13+j)%16 = beat j, wrap at 15->0.
REQ-026 Nine consecutive misses -> update_way 0..7 then 0.
REQ-027 flush after 5 beats -> remaining 11 consumed, no do_update_line, busy drops after 16th beat, victim unchanged.
REQ-028 mem_req_ready low 4 cycles -> mem_req_valid/addr stable, single handshake; miss_valid pulses while busy ignored.
REQ-029 rst mid-RECV (beat 7) -> all outputs 0 immediately, next miss refills cleanly with update_way 0.
